// File: rtl/wts_i2s_pkg.sv
// Shared constants and sample-to-I2S word conversion for the wave table I2S transmitter.
// Sample-to-word conversion lives here so every build uses the same conversion.
package wts_i2s_pkg;

  localparam int WTS_I2S_SLOTS     = 32;
  localparam int WTS_I2S_WORD_BITS = 16;
  localparam int WTS_SAMPLE_BITS   = 12;

  typedef logic [$clog2(WTS_I2S_SLOTS)-1:0] wts_slot_t;

  // Offset-binary input has its MSB inverted to become two's complement; the
  // 12-bit value is then left-aligned in the 16-bit word so the sign is kept.
  function automatic logic [WTS_I2S_WORD_BITS-1:0] wts_to_i2s_word(
    input logic [WTS_SAMPLE_BITS-1:0] sample,
    input logic                       offset
  );
    logic [WTS_SAMPLE_BITS-1:0] s12;
    s12 = offset ? (sample ^ 12'h800) : sample;
    return {s12, {(WTS_I2S_WORD_BITS-WTS_SAMPLE_BITS){1'b0}}};
  endfunction

endpackage

// File: rtl/wts_i2s_bclk_gen.sv
// BCLK generator: integer divider of clk plus the BCLK register.
// bclk_fall is high during the clk cycle whose closing edge drives BCLK 1->0.
module wts_i2s_bclk_gen #(
  parameter int BCLK_DIV = 4
) (
  input  logic clk,
  input  logic reset,
  input  logic enable,
  output logic i2s_bclk,
  output logic bclk_fall
);

  localparam int DIV_W = (BCLK_DIV > 1) ? $clog2(BCLK_DIV) : 1;
  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(BCLK_DIV - 1);

  logic [DIV_W-1:0] div;
  logic             div_wrap;

  assign div_wrap  = (div == DIV_LAST);
  // Gated by enable so a disable on a toggle edge never advances the serializer.
  assign bclk_fall = enable && div_wrap && i2s_bclk;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      div      <= '0;
      i2s_bclk <= 1'b0;
    end else if (!enable) begin
      div      <= '0;
      i2s_bclk <= 1'b0;
    end else if (div_wrap) begin
      div      <= '0;
      i2s_bclk <= ~i2s_bclk;
    end else begin
      div      <= div + DIV_W'(1);
    end
  end

endmodule

// File: rtl/wts_i2s_tx.sv
// Stereo Philips I2S master: captures 12-bit mixer samples once per frame and
// shifts them out MSB first as 16-bit words, one BCLK after each LRCK edge.
module wts_i2s_tx
  import wts_i2s_pkg::*;
#(
  parameter int BCLK_DIV     = 4,
  parameter int INPUT_OFFSET = 1
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       enable,
  input  logic [WTS_SAMPLE_BITS-1:0] left_in,
  input  logic [WTS_SAMPLE_BITS-1:0] right_in,
  output logic                       sample_strobe,
  output logic                       i2s_bclk,
  output logic                       i2s_lrck,
  output logic                       i2s_sdata
);

  localparam int        SR_BITS   = 2 * WTS_I2S_WORD_BITS;
  localparam logic      OFFSET_EN = (INPUT_OFFSET != 0);
  localparam wts_slot_t HALF_SLOT = wts_slot_t'(WTS_I2S_SLOTS / 2);

  logic               bclk_fall;
  wts_slot_t          slot;
  wts_slot_t          slot_next;
  logic [SR_BITS-1:0] sr;

  wts_i2s_bclk_gen #(
    .BCLK_DIV (BCLK_DIV)
  ) u_bclk_gen (
    .clk       (clk),
    .reset     (reset),
    .enable    (enable),
    .i2s_bclk  (i2s_bclk),
    .bclk_fall (bclk_fall)
  );

  // Slot counter wraps 31 -> 0 through natural 5-bit overflow.
  assign slot_next = slot + wts_slot_t'(1);
  assign i2s_sdata = sr[SR_BITS-1];

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      slot          <= '0;
      sr            <= '0;
      i2s_lrck      <= 1'b0;
      sample_strobe <= 1'b0;
    end else if (!enable) begin
      slot          <= '0;
      sr            <= '0;
      i2s_lrck      <= 1'b0;
      sample_strobe <= 1'b0;
    end else begin
      sample_strobe <= 1'b0;
      if (bclk_fall) begin
        slot     <= slot_next;
        i2s_lrck <= (slot_next >= HALF_SLOT);
        // Loading at slot 1 leaves slot 0 for the previous right LSB.
        if (slot_next == wts_slot_t'(1)) begin
          sr            <= {wts_to_i2s_word(left_in, OFFSET_EN),
                            wts_to_i2s_word(right_in, OFFSET_EN)};
          sample_strobe <= 1'b1;
        end else begin
          sr            <= {sr[SR_BITS-2:0], 1'b0};
        end
      end
    end
  end

endmodule

// File: tb/tb_wts_i2s_tx.sv
// Bench for wts_i2s_tx: three builds (DIV=4 offset, DIV=4 two's complement,
// DIV=1 offset) decoded from their serial pins and compared with an arithmetic model.
module tb_wts_i2s_tx;

  logic        clk = 1'b0;
  logic        reset;
  logic        enable;
  logic [11:0] left_in;
  logic [11:0] right_in;

  logic a_strobe, a_bclk, a_lrck, a_sdata;
  logic b_strobe, b_bclk, b_lrck, b_sdata;
  logic c_strobe, c_bclk, c_lrck, c_sdata;
  logic m_strobe, m_bclk, m_lrck, m_sdata;
  int   sel;

  int pass_cnt  = 0;
  int total_cnt = 0;

  always #5 clk = ~clk;

  wts_i2s_tx #(.BCLK_DIV(4), .INPUT_OFFSET(1)) dut_a (
    .clk(clk), .reset(reset), .enable(enable), .left_in(left_in), .right_in(right_in),
    .sample_strobe(a_strobe), .i2s_bclk(a_bclk), .i2s_lrck(a_lrck), .i2s_sdata(a_sdata));

  wts_i2s_tx #(.BCLK_DIV(4), .INPUT_OFFSET(0)) dut_b (
    .clk(clk), .reset(reset), .enable(enable), .left_in(left_in), .right_in(right_in),
    .sample_strobe(b_strobe), .i2s_bclk(b_bclk), .i2s_lrck(b_lrck), .i2s_sdata(b_sdata));

  wts_i2s_tx #(.BCLK_DIV(1), .INPUT_OFFSET(1)) dut_c (
    .clk(clk), .reset(reset), .enable(enable), .left_in(left_in), .right_in(right_in),
    .sample_strobe(c_strobe), .i2s_bclk(c_bclk), .i2s_lrck(c_lrck), .i2s_sdata(c_sdata));

  always_comb begin
    m_strobe = a_strobe; m_bclk = a_bclk; m_lrck = a_lrck; m_sdata = a_sdata;
    if (sel == 1) begin
      m_strobe = b_strobe; m_bclk = b_bclk; m_lrck = b_lrck; m_sdata = b_sdata;
    end else if (sel == 2) begin
      m_strobe = c_strobe; m_bclk = c_bclk; m_lrck = c_lrck; m_sdata = c_sdata;
    end
  end

  // Reference: sample as a signed integer, scaled by 16 into a 16-bit word.
  function automatic logic [15:0] model_word(input logic [11:0] s, input bit offset);
    int v;
    if (offset) v = int'(s) - 2048;
    else        v = (int'(s) >= 2048) ? int'(s) - 4096 : int'(s);
    return 16'(v * 16);
  endfunction

  // Decode one frame from the selected build: bits sampled at BCLK rising edges
  // from slot 1 through slot 0 of the next frame, LRCK checked against slot index.
  task automatic capture_frame(input bit already_strobed, output logic [15:0] l,
                               output logic [15:0] r, output int lrck_err, output bit ok);
    logic [31:0] bits;
    logic        pb;
    logic        exp_lr;
    int          k;
    int          n;
    bits = '0; lrck_err = 0; ok = 1'b0; k = 0; l = '0; r = '0;
    if (!already_strobed) begin
      n = 0;
      do begin
        @(posedge clk); #1; n++;
      end while (!m_strobe && n < 2000);
      if (!m_strobe) return;
    end
    pb = m_bclk;
    n = 0;
    while (k < 32 && n < 2000) begin
      @(posedge clk); #1; n++;
      if (m_bclk && !pb) begin
        bits   = {bits[30:0], m_sdata};
        exp_lr = (((k + 1) % 32) >= 16);
        if (m_lrck !== exp_lr) lrck_err++;
        k++;
      end
      pb = m_bclk;
    end
    ok = (k == 32);
    l  = bits[31:16];
    r  = bits[15:0];
  endtask

  task automatic test_reset();
    int first_rise_a, first_strobe_a, first_strobe_b, first_strobe_c;
    #1;
    total_cnt++;
    if ({a_strobe, a_bclk, a_lrck, a_sdata, b_strobe, b_bclk, b_lrck, b_sdata,
         c_strobe, c_bclk, c_lrck, c_sdata} !== 12'h000)
      $display("FAIL reset_outputs: got %b %b %b want all 0",
               {a_strobe, a_bclk, a_lrck, a_sdata}, {b_strobe, b_bclk, b_lrck, b_sdata},
               {c_strobe, c_bclk, c_lrck, c_sdata});
    else pass_cnt++;
    enable = 1'b1;
    @(negedge clk); reset = 1'b0;
    first_rise_a = -1; first_strobe_a = -1; first_strobe_b = -1; first_strobe_c = -1;
    for (int e = 1; e <= 40; e++) begin
      @(posedge clk); #1;
      if (a_bclk   && first_rise_a   < 0) first_rise_a   = e;
      if (a_strobe && first_strobe_a < 0) first_strobe_a = e;
      if (b_strobe && first_strobe_b < 0) first_strobe_b = e;
      if (c_strobe && first_strobe_c < 0) first_strobe_c = e;
    end
    total_cnt++;
    if (first_rise_a !== 4) $display("FAIL first_bclk_rise_div4: got %0d want 4", first_rise_a);
    else pass_cnt++;
    total_cnt++;
    if (first_strobe_a !== 8) $display("FAIL first_strobe_div4: got %0d want 8", first_strobe_a);
    else pass_cnt++;
    total_cnt++;
    if (first_strobe_b !== 8) $display("FAIL first_strobe_div4_tc: got %0d want 8", first_strobe_b);
    else pass_cnt++;
    total_cnt++;
    if (first_strobe_c !== 2) $display("FAIL first_strobe_div1: got %0d want 2", first_strobe_c);
    else pass_cnt++;
    // Mid-frame asynchronous reset, checked between clock edges.
    repeat (93) @(posedge clk);
    #2 reset = 1'b1;
    #1;
    total_cnt++;
    if ({a_strobe, a_bclk, a_lrck, a_sdata, b_strobe, b_bclk, b_lrck, b_sdata,
         c_strobe, c_bclk, c_lrck, c_sdata} !== 12'h000)
      $display("FAIL async_reset_midframe: got %b %b %b want all 0",
               {a_strobe, a_bclk, a_lrck, a_sdata}, {b_strobe, b_bclk, b_lrck, b_sdata},
               {c_strobe, c_bclk, c_lrck, c_sdata});
    else pass_cnt++;
    @(negedge clk); reset = 1'b0;
  endtask

  task automatic test_fixed(input int s, input logic [11:0] lv, input logic [11:0] rv,
                            input logic [15:0] exp_l, input logic [15:0] exp_r);
    logic [15:0] l, r;
    int          le;
    bit          ok;
    sel = s; left_in = lv; right_in = rv;
    capture_frame(1'b0, l, r, le, ok);
    total_cnt++;
    if (!ok || le != 0)
      $display("FAIL fixed_frame_sel%0d: ok=%0d lrck_errors=%0d want ok=1 errors=0", s, ok, le);
    else pass_cnt++;
    total_cnt++;
    if ({l, r} !== {exp_l, exp_r})
      $display("FAIL fixed_words_sel%0d in=%h/%h: got %h/%h want %h/%h", s, lv, rv, l, r, exp_l, exp_r);
    else pass_cnt++;
  endtask

  task automatic test_random(input int s, input bit offset, input int frames);
    logic [15:0] l, r;
    logic [11:0] lv, rv;
    int          le;
    bit          ok;
    sel = s;
    for (int i = 0; i < frames; i++) begin
      lv = 12'($urandom_range(0, 4095));
      rv = 12'($urandom_range(0, 4095));
      left_in = lv; right_in = rv;
      capture_frame(1'b0, l, r, le, ok);
      total_cnt++;
      if (!ok || le != 0 || {l, r} !== {model_word(lv, offset), model_word(rv, offset)})
        $display("FAIL random_frame_sel%0d #%0d in=%h/%h: got %h/%h ok=%0d lrck_err=%0d want %h/%h",
                 s, i, lv, rv, l, r, ok, le, model_word(lv, offset), model_word(rv, offset));
      else pass_cnt++;
    end
  endtask

  task automatic test_midframe();
    logic [15:0] l, r;
    logic [11:0] old_v, new_v, rv;
    int          le;
    bit          ok;
    sel = 0;
    old_v = 12'($urandom_range(0, 4095));
    new_v = old_v ^ 12'h5A5;
    rv    = 12'($urandom_range(0, 4095));
    left_in = old_v; right_in = rv;
    fork
      capture_frame(1'b0, l, r, le, ok);
      begin
        int n;
        n = 0;
        do begin @(posedge clk); #1; n++; end while (!a_strobe && n < 2000);
        repeat (64) @(posedge clk);
        #1 left_in = new_v;
      end
    join
    total_cnt++;
    if (!ok || {l, r} !== {model_word(old_v, 1'b1), model_word(rv, 1'b1)})
      $display("FAIL midframe_current: got %h/%h ok=%0d want %h/%h",
               l, r, ok, model_word(old_v, 1'b1), model_word(rv, 1'b1));
    else pass_cnt++;
    capture_frame(1'b0, l, r, le, ok);
    total_cnt++;
    if (!ok || l !== model_word(new_v, 1'b1))
      $display("FAIL midframe_next: got %h ok=%0d want %h", l, ok, model_word(new_v, 1'b1));
    else pass_cnt++;
  endtask

  task automatic test_framing(input int s, input int div);
    int  c, last_strobe, strobe_gaps, bad_strobe_gap;
    int  last_brise, bclk_per, last_lrise, lrck_per, bad_change;
    logic pb, pl, pd;
    sel = s;
    last_strobe = -1; strobe_gaps = 0; bad_strobe_gap = 0;
    last_brise = -1; bclk_per = -1; last_lrise = -1; lrck_per = -1; bad_change = 0;
    @(posedge clk); #1;
    pb = m_bclk; pl = m_lrck; pd = m_sdata;
    for (c = 0; c < 200 * div + 40; c++) begin
      @(posedge clk); #1;
      if (m_strobe) begin
        if (last_strobe >= 0) begin
          strobe_gaps++;
          if (c - last_strobe != 64 * div) bad_strobe_gap++;
        end
        last_strobe = c;
      end
      if (m_bclk && !pb) begin
        if (last_brise >= 0) bclk_per = c - last_brise;
        last_brise = c;
      end
      if (m_lrck && !pl) begin
        if (last_lrise >= 0) lrck_per = c - last_lrise;
        last_lrise = c;
      end
      if ((m_lrck !== pl || m_sdata !== pd) && !(pb && !m_bclk)) bad_change++;
      pb = m_bclk; pl = m_lrck; pd = m_sdata;
    end
    total_cnt++;
    if (strobe_gaps < 2 || bad_strobe_gap != 0)
      $display("FAIL strobe_spacing_sel%0d: gaps=%0d bad=%0d want >=2 gaps of %0d", s,
               strobe_gaps, bad_strobe_gap, 64 * div);
    else pass_cnt++;
    total_cnt++;
    if (bclk_per != 2 * div) $display("FAIL bclk_period_sel%0d: got %0d want %0d", s, bclk_per, 2 * div);
    else pass_cnt++;
    total_cnt++;
    if (lrck_per != 64 * div) $display("FAIL lrck_period_sel%0d: got %0d want %0d", s, lrck_per, 64 * div);
    else pass_cnt++;
    total_cnt++;
    if (bad_change != 0) $display("FAIL change_off_bclk_fall_sel%0d: got %0d want 0", s, bad_change);
    else pass_cnt++;
  endtask

  task automatic test_enable(input int s, input int div);
    logic [15:0] l, r;
    logic [11:0] lv, rv;
    int          le, n, e;
    bit          ok;
    sel = s;
    n = 0;
    do begin @(posedge clk); #1; n++; end while (!m_strobe && n < 2000);
    repeat (19 * 2 * div) @(posedge clk);
    #1;
    total_cnt++;
    if (m_lrck !== 1'b1) $display("FAIL slot20_lrck_sel%0d: got %b want 1", s, m_lrck);
    else pass_cnt++;
    enable = 1'b0;
    @(posedge clk); #1;
    total_cnt++;
    if ({m_strobe, m_bclk, m_lrck, m_sdata} !== 4'b0000)
      $display("FAIL disable_clear_sel%0d: got %b want 0000", s, {m_strobe, m_bclk, m_lrck, m_sdata});
    else pass_cnt++;
    repeat (5) @(posedge clk);
    #1;
    lv = 12'($urandom_range(0, 4095));
    rv = 12'($urandom_range(0, 4095));
    left_in = lv; right_in = rv;
    enable = 1'b1;
    e = 0;
    do begin @(posedge clk); #1; e++; end while (!m_strobe && e < 600);
    total_cnt++;
    if (e != 2 * div) $display("FAIL reenable_first_strobe_sel%0d: got %0d want %0d", s, e, 2 * div);
    else pass_cnt++;
    capture_frame(1'b1, l, r, le, ok);
    total_cnt++;
    if (!ok || le != 0 || {l, r} !== {model_word(lv, 1'b1), model_word(rv, 1'b1)})
      $display("FAIL reenable_frame_sel%0d: got %h/%h ok=%0d lrck_err=%0d want %h/%h", s, l, r,
               ok, le, model_word(lv, 1'b1), model_word(rv, 1'b1));
    else pass_cnt++;
  endtask

  initial begin
    reset = 1'b1; enable = 1'b0; left_in = '0; right_in = '0; sel = 0;
    repeat (3) @(posedge clk);
    test_reset();
    test_fixed(0, 12'hFFF, 12'h000, 16'h7FF0, 16'h8000);
    test_fixed(0, 12'h800, 12'h7FF, 16'h0000, 16'hFFF0);
    test_fixed(1, 12'h123, 12'hE00, 16'h1230, 16'hE000);
    test_random(0, 1'b1, 5);
    test_random(1, 1'b0, 3);
    test_random(2, 1'b1, 4);
    test_midframe();
    test_framing(0, 4);
    test_framing(2, 1);
    test_enable(0, 4);
    test_enable(2, 1);
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
